// File: rtl/dm_result_checker_pkg.sv
// Shared types and constants for the DM result checker.
// The optional cycle-report check is enabled with `define RDCYCLE_CHECK_EN.
package dm_result_checker_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCAN  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } chk_state_e;

  // Word the program writes to SIM_END_ADDR to signal completion.
  localparam logic [31:0] SIM_END_CODE = 32'hFFFF_FFFF;

  // Default placement of the result window and the end marker in DM.
  localparam int unsigned DEF_TEST_START   = 32'h2000;
  localparam int unsigned DEF_SIM_END_ADDR = 32'h3fff;

endpackage

// File: rtl/dm_result_checker_if.sv
// DM snoop bus, DM check read port and golden ROM port seen by the checker.
// master: the checker side. slave: the memory/arbiter/ROM side.
interface dm_result_checker_if #(
  parameter int ADDR_W    = 14,
  parameter int DATA_W    = 32,
  parameter int NUM_WORDS = 64
);
  localparam int GA_W = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;

  logic              dm_cs;
  logic [3:0]        dm_web;
  logic [ADDR_W-1:0] dm_addr;
  logic [DATA_W-1:0] dm_di;

  logic              chk_req;
  logic              chk_gnt;
  logic [ADDR_W-1:0] chk_addr;
  logic [DATA_W-1:0] chk_rdata;

  logic [GA_W-1:0]   gold_addr;
  logic [DATA_W-1:0] gold_rdata;

  modport master (
    input  dm_cs, dm_web, dm_addr, dm_di, chk_gnt, chk_rdata, gold_rdata,
    output chk_req, chk_addr, gold_addr
  );

  modport slave (
    output dm_cs, dm_web, dm_addr, dm_di, chk_gnt, chk_rdata, gold_rdata,
    input  chk_req, chk_addr, gold_addr
  );

endinterface

// File: rtl/dm_result_checker_cycle_counter.sv
// 64-bit run-time counter for the result checker: counts while not frozen
// and flags the last cycle before the timeout limit.
module chk_cycle_counter #(
  parameter longint unsigned MAX_CYCLES = 100000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        freeze_i,
  output logic [63:0] cnt_o,
  output logic        limit_o
);

  logic [63:0] cnt_q;

  // Count every unfrozen cycle since reset release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (!freeze_i) begin
      cnt_q <= cnt_q + 64'd1;
    end
  end

  assign cnt_o   = cnt_q;
  assign limit_o = (cnt_q == 64'(MAX_CYCLES - 1));

endmodule

// File: rtl/dm_result_checker.sv
// DM result checker: waits for the end-of-program marker written to DM,
// then reads the result window through the check port and compares it
// word by word with the golden ROM. Reports done/pass/timeout/err_cnt and
// the program cycle count.
// `define RDCYCLE_CHECK_EN additionally reads two words past the window and
// checks the program's own cycle report against cycle_cnt (rdcycle_ok).
module dm_result_checker
  import dm_result_checker_pkg::*;
#(
  parameter int              ADDR_W       = 14,
  parameter int              DATA_W       = 32,
  parameter int unsigned     TEST_START   = DEF_TEST_START,
  parameter int              NUM_WORDS    = 64,
  parameter int unsigned     SIM_END_ADDR = DEF_SIM_END_ADDR,
  parameter longint unsigned MAX_CYCLES   = 100000,
  parameter int              RDCYCLE_TOL  = 20
) (
  input  logic                           clk,
  input  logic                           rst_n,
  dm_result_checker_if.master            bus,
  output logic                           done,
  output logic                           pass,
  output logic                           timeout,
  output logic [$clog2(NUM_WORDS+1)-1:0] err_cnt,
  output logic [63:0]                    cycle_cnt
`ifdef RDCYCLE_CHECK_EN
  ,
  output logic                           rdcycle_ok
`endif
);

`ifdef RDCYCLE_CHECK_EN
  localparam int NREADS = NUM_WORDS + 2;
`else
  localparam int NREADS = NUM_WORDS;
`endif
  localparam int IDX_W = (NREADS > 1) ? $clog2(NREADS) : 1;
  localparam int GA_W  = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
  localparam int ERR_W = $clog2(NUM_WORDS + 1);

  localparam logic [1:0] S_IDLE  = IDLE;
  localparam logic [1:0] S_SCAN  = SCAN;
  localparam logic [1:0] S_DRAIN = DRAIN;
  localparam logic [1:0] S_DONE  = DONE;

  logic [1:0]       state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             cmp_vld_q;
  logic [IDX_W-1:0] cmp_idx_q;
  logic [ERR_W-1:0] err_q;
  logic             timeout_q;

  logic             end_detect;
  logic             accept;
  logic             last_accept;
  logic             at_limit;
  logic             timeout_evt;
  logic             is_gold;

  // Only a full-word write of the end code to the marker address counts.
  assign end_detect = bus.dm_cs && (bus.dm_web == 4'b0000) &&
                      (bus.dm_addr == ADDR_W'(SIM_END_ADDR)) &&
                      (bus.dm_di == DATA_W'(SIM_END_CODE));

  assign accept      = (state_q == S_SCAN) && bus.chk_gnt;
  assign last_accept = accept && (idx_q == IDX_W'(NREADS - 1));
  assign timeout_evt = (state_q == S_IDLE) && !end_detect && at_limit;

  chk_cycle_counter #(
    .MAX_CYCLES (MAX_CYCLES)
  ) u_cycle_counter (
    .clk      (clk),
    .rst_n    (rst_n),
    .freeze_i ((state_q != S_IDLE) || end_detect),
    .cnt_o    (cycle_cnt),
    .limit_o  (at_limit)
  );

  // Next-state and read-index logic; the index stays on the last word so
  // the address holds once the scan is over.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    case (state_q)
      S_IDLE: begin
        if (end_detect) begin
          state_d = S_SCAN;
          idx_d   = '0;
        end else if (at_limit) begin
          state_d = S_DONE;
        end
      end
      S_SCAN: begin
        if (last_accept) begin
          state_d = S_DRAIN;
        end else if (accept) begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      S_DRAIN: state_d = S_DONE;
      default: state_d = state_q;
    endcase
  end

  // State and index registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

`ifdef RDCYCLE_CHECK_EN
  assign is_gold       = (cmp_idx_q < IDX_W'(NUM_WORDS));
  assign bus.gold_addr = (idx_q < IDX_W'(NUM_WORDS)) ? GA_W'(idx_q) : GA_W'(NUM_WORDS - 1);
`else
  assign is_gold       = 1'b1;
  assign bus.gold_addr = GA_W'(idx_q);
`endif

  // Compare each returned word one cycle after its accept; a timeout
  // forces the error count to its saturated value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmp_vld_q <= 1'b0;
      cmp_idx_q <= '0;
      err_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      cmp_vld_q <= accept;
      cmp_idx_q <= idx_q;
      if (timeout_evt) begin
        timeout_q <= 1'b1;
        err_q     <= ERR_W'(NUM_WORDS);
      end else if (cmp_vld_q && is_gold && (bus.chk_rdata !== bus.gold_rdata) &&
                   (err_q != ERR_W'(NUM_WORDS))) begin
        err_q <= err_q + ERR_W'(1);
      end
    end
  end

  assign bus.chk_req  = (state_q == S_SCAN);
  assign bus.chk_addr = ADDR_W'(TEST_START) + ADDR_W'(idx_q);
  assign done         = (state_q == S_DONE);
  assign timeout      = timeout_q;
  assign err_cnt      = err_q;

`ifdef RDCYCLE_CHECK_EN
  logic        rdok_q;
  logic signed [31:0] rd_diff;

  assign rd_diff = cycle_cnt[31:0] - bus.chk_rdata[31:0];

  // Judge the program's cycle report when the last extra word returns.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdok_q <= 1'b0;
    end else if (cmp_vld_q && (cmp_idx_q == IDX_W'(NREADS - 1))) begin
      rdok_q <= (rd_diff < RDCYCLE_TOL);
    end
  end

  assign rdcycle_ok = rdok_q;
  assign pass       = done & ~timeout_q & (err_q == '0) & rdok_q;
`else
  assign pass       = done & ~timeout_q & (err_q == '0);
`endif

endmodule

// File: tb/tb_dm_result_checker.sv
// Self-checking bench for dm_result_checker. Acts as DM check port, arbiter
// and golden ROM; expected results come from a word-level model of the
// result window and the grant sequence.
`timescale 1ns/1ps
module tb_dm_result_checker;
  import dm_result_checker_pkg::*;

  localparam int NW   = 64;
  localparam int MAXC = 1000;
`ifdef RDCYCLE_CHECK_EN
  localparam int NREADS = NW + 2;
`else
  localparam int NREADS = NW;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        done, pass, timeout;
  logic [6:0]  err_cnt;
  logic [63:0] cycle_cnt;
`ifdef RDCYCLE_CHECK_EN
  logic        rdcycle_ok;
`endif

  dm_result_checker_if #(.ADDR_W(14), .DATA_W(32), .NUM_WORDS(NW)) bus ();

  dm_result_checker #(
    .NUM_WORDS  (NW),
    .MAX_CYCLES (MAXC)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus),
    .done       (done),
    .pass       (pass),
    .timeout    (timeout),
    .err_cnt    (err_cnt),
    .cycle_cnt  (cycle_cnt)
`ifdef RDCYCLE_CHECK_EN
    ,
    .rdcycle_ok (rdcycle_ok)
`endif
  );

  always #5 clk = ~clk;

  logic [31:0] win  [NW+2];
  logic [31:0] gold [NW];
  int          cyc;
  int          gntMode = 0;
  int          scanBase = 0;
  bit          gntPat[$];
  logic [13:0] acceptLog[$];
  int          reqCount = 0;
  int          passCnt = 0;
  int          failCnt = 0;
  int          totalCnt = 0;

  function automatic bit gntAt(input int c);
    int k;
    if (gntMode == 0) return 1'b1;
    k = c - scanBase;
    if (k >= 0 && k < gntPat.size()) return gntPat[k];
    return 1'b1;
  endfunction

  // Cycle number since reset release, as the checker should count it.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  // Arbiter: grant changes mid-cycle from the chosen pattern.
  always @(negedge clk) begin
    bus.chk_gnt = gntAt(cyc);
  end

  // DM check port and golden ROM, both with one cycle of read latency.
  always @(posedge clk) begin
    if (bus.chk_req === 1'b1 && bus.chk_gnt === 1'b1) begin
      bus.chk_rdata <= win[int'(bus.chk_addr - 14'h2000)];
      acceptLog.push_back(bus.chk_addr);
    end else begin
      bus.chk_rdata <= $urandom;
    end
    bus.gold_rdata <= gold[bus.gold_addr];
    if (bus.chk_req === 1'b1) reqCount <= reqCount + 1;
  end

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    totalCnt++;
    assert (obs === exp) passCnt++;
    else begin
      failCnt++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic [3:0] web, input logic [13:0] addr, input logic [31:0] data);
    bus.dm_cs   = 1'b1;
    bus.dm_web  = web;
    bus.dm_addr = addr;
    bus.dm_di   = data;
    @(negedge clk);
    bus.dm_cs   = 1'b0;
    bus.dm_web  = 4'hF;
  endtask

  task automatic doReset();
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic waitUntilCyc(input int c);
    int guard = 0;
    while (cyc != c && guard < 5000) begin
      @(negedge clk);
      guard++;
    end
    checkOutput("sync_cycle", 64'(cyc), 64'(c));
  endtask

  task automatic waitDone(input int budget, output int doneCyc);
    doneCyc = -1;
    for (int i = 0; i < budget; i++) begin
      if (done === 1'b1) begin
        doneCyc = cyc;
        break;
      end
      @(negedge clk);
    end
  endtask

  // Fresh golden data; the window starts as an exact copy of it.
  task automatic fillWindow(input int corruptOneIn);
    for (int i = 0; i < NW; i++) begin
      gold[i] = $urandom;
      win[i]  = gold[i];
      if (corruptOneIn > 0 && $urandom_range(0, corruptOneIn - 1) == 0)
        win[i] = gold[i] ^ (32'h1 << $urandom_range(0, 31));
    end
    win[NW]   = $urandom;
    win[NW+1] = $urandom;
  endtask

  function automatic int modelErr();
    int n = 0;
    for (int i = 0; i < NW; i++) if (win[i] != gold[i]) n++;
    return n;
  endfunction

  function automatic bit modelRdOk(input int t);
    return $signed(32'(t) - win[NW+1]) < 20;
  endfunction

  function automatic bit modelPass(input int t);
    bit ok = (modelErr() == 0);
`ifdef RDCYCLE_CHECK_EN
    ok = ok && modelRdOk(t);
`endif
    return ok;
  endfunction

  function automatic int modelDoneCycle(input int t);
    int c = t;
    int grants = 0;
    while (grants < NREADS) begin
      c++;
      if (gntAt(c)) grants++;
    end
    return c + 2;
  endfunction

  // End marker at cycle t, then the full set of end-of-scan checks.
  task automatic runScan(input string name, input int t, input int rdDelta);
    int startIdx, dc, bad, n;
    win[NW+1] = 32'(t - rdDelta);
    scanBase  = t + 1;
    waitUntilCyc(t);
    startIdx = acceptLog.size();
    applyStimulus(4'b0000, 14'h3fff, SIM_END_CODE);
    checkOutput({name, "_req_start"}, 64'(bus.chk_req), 64'd1);
    waitDone(400, dc);
    checkOutput({name, "_done_cycle"}, 64'(dc), 64'(modelDoneCycle(t)));
    checkOutput({name, "_err_cnt"}, 64'(err_cnt), 64'(modelErr()));
    checkOutput({name, "_pass"}, 64'(pass), 64'(modelPass(t)));
    checkOutput({name, "_timeout"}, 64'(timeout), 64'd0);
    checkOutput({name, "_cycle_cnt"}, cycle_cnt, 64'(t));
    checkOutput({name, "_req_off"}, 64'(bus.chk_req), 64'd0);
`ifdef RDCYCLE_CHECK_EN
    checkOutput({name, "_rdcycle_ok"}, 64'(rdcycle_ok), 64'(modelRdOk(t)));
`endif
    n   = acceptLog.size() - startIdx;
    bad = 0;
    for (int j = 0; j < n; j++)
      if (acceptLog[startIdx + j] !== 14'(32'h2000 + j)) bad++;
    checkOutput({name, "_addr_count"}, 64'(n), 64'(NREADS));
    checkOutput({name, "_addr_order"}, 64'(bad), 64'd0);
  endtask

  initial begin
    int dc, reqStart;
    bus.dm_cs   = 1'b0;
    bus.dm_web  = 4'hF;
    bus.dm_addr = '0;
    bus.dm_di   = '0;
    fillWindow(0);

    // Reset values while reset is held.
    #12;
    checkOutput("rst_chk_req", 64'(bus.chk_req), 64'd0);
    checkOutput("rst_chk_addr", 64'(bus.chk_addr), 64'h2000);
    checkOutput("rst_gold_addr", 64'(bus.gold_addr), 64'd0);
    checkOutput("rst_done", 64'(done), 64'd0);
    checkOutput("rst_pass", 64'(pass), 64'd0);
    checkOutput("rst_timeout", 64'(timeout), 64'd0);
    checkOutput("rst_err_cnt", 64'(err_cnt), 64'd0);
    checkOutput("rst_cycle_cnt", cycle_cnt, 64'd0);

    // Clean window, full grant, end marker at 500.
    doReset();
    @(negedge clk);
    checkOutput("first_cycle_cnt", cycle_cnt, 64'd1);
    gntMode = 0;
    runScan("clean", 500, 5);
    applyStimulus(4'b0000, 14'h3fff, SIM_END_CODE);
    repeat (3) @(negedge clk);
    checkOutput("remark_done", 64'(done), 64'd1);
    checkOutput("remark_req", 64'(bus.chk_req), 64'd0);
    checkOutput("remark_cycle_cnt", cycle_cnt, 64'd500);

    // Words 3 and 63 corrupted; a partial-byte marker must not trigger.
    doReset();
    fillWindow(0);
    win[3]  = gold[3] ^ 32'h0000_0100;
    win[63] = gold[63] ^ 32'h8000_0000;
    waitUntilCyc(200);
    applyStimulus(4'b1110, 14'h3fff, SIM_END_CODE);
    waitUntilCyc(203);
    checkOutput("partial_no_req", 64'(bus.chk_req), 64'd0);
    checkOutput("partial_counting", cycle_cnt, 64'd203);
    runScan("corrupt", 205, 3);
    checkOutput("corrupt_err_two", 64'(err_cnt), 64'd2);

    // Grant pattern 1,0,0 repeating, a few random corrupted words.
    doReset();
    fillWindow(8);
    gntPat.delete();
    for (int k = 0; k < 300; k++) gntPat.push_back(k % 3 == 0);
    gntMode = 1;
    runScan("gnt100", 300, 2);

    // Random grants and random corruption at a random end cycle.
    doReset();
    fillWindow(5);
    gntPat.delete();
    for (int k = 0; k < 400; k++) gntPat.push_back($urandom_range(0, 3) != 0);
    runScan("gntrand", $urandom_range(100, 400), $urandom_range(0, 40));
    gntMode = 0;

    // Reset asserted in the middle of a scan.
    doReset();
    fillWindow(0);
    waitUntilCyc(50);
    applyStimulus(4'b0000, 14'h3fff, SIM_END_CODE);
    repeat (20) @(negedge clk);
    #3 rst_n = 1'b0;
    #1;
    checkOutput("abort_chk_req", 64'(bus.chk_req), 64'd0);
    checkOutput("abort_chk_addr", 64'(bus.chk_addr), 64'h2000);
    checkOutput("abort_gold_addr", 64'(bus.gold_addr), 64'd0);
    checkOutput("abort_done", 64'(done), 64'd0);
    checkOutput("abort_err_cnt", 64'(err_cnt), 64'd0);
    checkOutput("abort_cycle_cnt", cycle_cnt, 64'd0);

    // No end marker: timeout after MAXC cycles.
    doReset();
    reqStart = reqCount;
    waitDone(MAXC + 100, dc);
    checkOutput("to_done_cycle", 64'(dc), 64'(MAXC));
    checkOutput("to_timeout", 64'(timeout), 64'd1);
    checkOutput("to_err_cnt", 64'(err_cnt), 64'(NW));
    checkOutput("to_pass", 64'(pass), 64'd0);
    checkOutput("to_cycle_cnt", cycle_cnt, 64'(MAXC));
    applyStimulus(4'b0000, 14'h3fff, SIM_END_CODE);
    repeat (2) @(negedge clk);
    checkOutput("to_no_req", 64'(reqCount - reqStart), 64'd0);

    // End marker in the last cycle before timeout wins over the timeout.
    doReset();
    fillWindow(0);
    runScan("lastcycle", MAXC - 1, 7);

`ifdef RDCYCLE_CHECK_EN
    // Cycle report just inside and exactly at the tolerance.
    doReset();
    fillWindow(0);
    runScan("rd_ok19", 400, 19);
    checkOutput("rd_ok19_flag", 64'(rdcycle_ok), 64'd1);
    doReset();
    fillWindow(0);
    runScan("rd_bad20", 400, 20);
    checkOutput("rd_bad20_flag", 64'(rdcycle_ok), 64'd0);
    checkOutput("rd_bad20_pass", 64'(pass), 64'd0);
`endif

    $display("%0d/%0d checks passed", passCnt, totalCnt);
    $finish;
  end

endmodule

// File: doc/dm_result_checker.md
# dm_result_checker

Synthesizable self-check monitor beside the data memory (DM1) in the CPU top. It snoops DM writes for the end-of-program marker and then scans the test-result window of DM against a golden ROM over a shared read port. It reports pass/fail, error count and total cycle count, and flags a timeout. It replaces bench-side memory peeking, so the same check runs in RTL, gate-level and FPGA builds.

## Interface
- `ADDR_W`, default 14: DM word-address width (16K words).
- `DATA_W`, default 32: DM word width.
- `TEST_START`, default 'h2000: first word address of the result window.
- `NUM_WORDS`, default 64: number of golden words, 1..1024.
- `SIM_END_ADDR`, default 'h3fff: word address of the end marker.
- `MAX_CYCLES`, default 100000: timeout, in cycles after reset release.
- `RDCYCLE_TOL`, default 20: cycle-report tolerance. Used only with `RDCYCLE_CHECK_EN`.
- `clk` in 1: single clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `dm_cs` in 1: DM chip select (snoop).
- `dm_web` in 4: DM byte write enables, active-low (snoop).
- `dm_addr` in ADDR_W: DM word address (snoop).
- `dm_di` in DATA_W: DM write data (snoop).
- `chk_req` out 1: read request on the DM check port.
- `chk_gnt` in 1: arbiter grant. A read is accepted when `chk_req && chk_gnt`.
- `chk_addr` out ADDR_W: DM read address.
- `chk_rdata` in DATA_W: DM data, valid the cycle after acceptance.
- `gold_addr` out $clog2(NUM_WORDS): golden ROM index.
- `gold_rdata` in DATA_W: golden word, 1-cycle latency, read in lockstep with `chk_addr`.
- `done` out 1: check finished (sticky).
- `pass` out 1: done with zero errors and no timeout.
- `timeout` out 1: MAX_CYCLES reached before the end marker.
- `err_cnt` out $clog2(NUM_WORDS+1): mismatching word count.
- `cycle_cnt` out 64: cycles since reset release; freezes at end detect.
- `rdcycle_ok` out 1: cycle report within tolerance. Exists only with `RDCYCLE_CHECK_EN`.

## Operation
- States: IDLE → SCAN → DRAIN → DONE. A timeout goes IDLE → DONE directly.
- End detect: all of `dm_cs=1`, `dm_web=4'b0000`, `dm_addr==SIM_END_ADDR`, `dm_di==32'hFFFF_FFFF` in one cycle.
  - Partial-byte writes never trigger, even if they assemble 0xFFFFFFFF.
- IDLE:
  - `cycle_cnt` increments every cycle.
  - On end detect: freeze `cycle_cnt`, go to SCAN, clear the word index.
- SCAN:
  - `chk_req=1`; `chk_addr = TEST_START + idx`; `gold_addr = idx`.
  - `idx` advances only on acceptance. With `chk_gnt=0`, address and request hold unchanged.
  - After the last accept, go to DRAIN.
- Compare, one cycle after each accept:
  - If `chk_rdata !== gold_rdata` (X/Z counts as mismatch in simulation), increment `err_cnt`.
  - `err_cnt` saturates at NUM_WORDS.
- DRAIN: one cycle to retire the final compare, then DONE.
- DONE:
  - `done=1`, `chk_req=0`; all outputs hold.
  - Further end markers are ignored until reset.
- Timeout: in IDLE with `cycle_cnt == MAX_CYCLES-1`, next cycle is DONE with `timeout=1`, `err_cnt=NUM_WORDS`, `pass=0`, and no scan.
- `pass = done & ~timeout & (err_cnt==0)`, plus `& rdcycle_ok` when the macro is enabled.
- End marker and timeout in the same cycle: end detect wins; normal scan.

## Timing
- Reset values:
  - `chk_req=0`, `chk_addr=TEST_START`, `gold_addr=0`.
  - `done`, `pass`, `timeout`, `rdcycle_ok` = 0.
  - `err_cnt=0`, `cycle_cnt=0`.
  - State IDLE.
- `cycle_cnt` reads 1 in the first cycle after `rst_n` deassertion edge.
- End write at cycle t → `chk_req=1` at t+1.
- Last accept at cycle L → `err_cnt` final at L+2, `done=1` at L+2.
- Full-grant scan: `done` at t+NUM_WORDS+2.
- `rst_n` low mid-scan aborts immediately (async); all outputs return to reset values.

## Configuration
- `RDCYCLE_CHECK_EN` defined:
  - The scan reads NUM_WORDS+2 words. The two extra words are not golden-compared.
  - `d = $signed(cycle_cnt[31:0] - word[TEST_START+NUM_WORDS+1])`.
  - `rdcycle_ok = (d < RDCYCLE_TOL)`, registered when the last word returns.
- Undefined: NUM_WORDS reads only; `rdcycle_ok` port absent; `pass` ignores it.

## Structure
- `checker_pkg`:
  - `chk_state_e` (IDLE/SCAN/DRAIN/DONE).
  - `SIM_END_CODE = 32'hFFFF_FFFF`.
  - Default `TEST_START` and `SIM_END_ADDR`.
- Sub-module `chk_cycle_counter`: 64-bit counter with freeze input and timeout compare.

## Test plan
- End write at cycle 500, grant always 1, DM window equals golden → `done` at 500+66, `pass=1`, `err_cnt=0`, `cycle_cnt` frozen at 500.
- Golden words 3 and 63 corrupted in DM → `err_cnt=2`, `pass=0`, `chk_addr` covers 'h2000..'h203f exactly once.
- `chk_gnt` toggles 1,0,0,1,… → no address skipped or repeated; `done` delayed by exactly the number of zero-grant cycles.
- No end marker, MAX_CYCLES=1000 → `timeout=1`, `done=1` at cycle 1000, `err_cnt=64`, `chk_req` never 1.
- End write with `dm_web=4'b1110` then full write 5 cycles later → detection only on the full write; `rst_n` pulsed mid-scan → all outputs at reset values.
- `RDCYCLE_CHECK_EN`, DM['h2041] = `cycle_cnt`-19 → `rdcycle_ok=1`; DM['h2041] = `cycle_cnt`-20 → `rdcycle_ok=0`, `pass=0`.
